// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, operand forwarding, memory-wait freeze with timeout.
// Latency: all control outputs are combinational from the current inputs and state; state/counters update on clk.
// Backpressure: a pending data-memory access freezes every pipeline enable until ack, drop, or a sticky timeout fault.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic [4:0]  rs_EX,
    input  logic [4:0]  rt_EX,
    input  logic        MemtoReg_EX,
    input  logic        RegWrite_EX,
    input  logic [4:0]  writeAddr_EX,
    input  logic        RegWrite_MEM,
    input  logic [4:0]  writeAddr_MEM,
    input  logic        RegWrite_WB,
    input  logic [4:0]  writeAddr_WB,
    input  logic        branch_taken_EX,
    input  logic        mem_req_MEM,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        en_IF2ID,
    output logic        en_ID2EX,
    output logic        en_EX2MEM,
    output logic        flush_IF2ID,
    output logic        bubble_ID2EX,
    output logic [1:0]  fwdA_EX,
    output logic [1:0]  fwdB_EX,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        FAULT   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_nxt;
    logic [15:0] stall_q;

    logic freeze;
    logic loaduse;
    logic lu_stall;

    // Freeze while an access is outstanding; a fault freezes forever.
    assign freeze  = (state == FAULT) || (mem_req_MEM && !mem_ack);

    // A load in EX feeding either source of the instruction in ID.
    assign loaduse = MemtoReg_EX && RegWrite_EX && (writeAddr_EX != 5'd0) &&
                     ((writeAddr_EX == rs_ID) || (writeAddr_EX == rt_ID));

    // A load-use bubble only happens when nothing stronger (freeze, branch) overrides it.
    assign lu_stall = !freeze && !branch_taken_EX && loaduse;

    // Forwarding source for one EX operand; the younger MEM result wins over WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (RegWrite_MEM && (writeAddr_MEM != 5'd0) && (writeAddr_MEM == src)) begin
            sel = 2'b10;
        end else if (RegWrite_WB && (writeAddr_WB != 5'd0) && (writeAddr_WB == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Pipeline enables, flush/bubble and forwarding selects; everything held low while in reset.
    always_comb begin
        pc_en        = 1'b0;
        en_IF2ID     = 1'b0;
        en_ID2EX     = 1'b0;
        en_EX2MEM    = 1'b0;
        flush_IF2ID  = 1'b0;
        bubble_ID2EX = 1'b0;
        fwdA_EX      = 2'b00;
        fwdB_EX      = 2'b00;
        if (rst_n) begin
            fwdA_EX = fwd_sel(rs_EX);
            fwdB_EX = fwd_sel(rt_EX);
            if (freeze) begin
                // everything holds; branch and load-use wait for the memory
            end else if (branch_taken_EX) begin
                pc_en        = 1'b1;
                en_IF2ID     = 1'b1;
                en_ID2EX     = 1'b1;
                en_EX2MEM    = 1'b1;
                flush_IF2ID  = 1'b1;
                bubble_ID2EX = 1'b1;
            end else if (loaduse) begin
                en_ID2EX     = 1'b1;
                en_EX2MEM    = 1'b1;
                bubble_ID2EX = 1'b1;
            end else begin
                pc_en        = 1'b1;
                en_IF2ID     = 1'b1;
                en_ID2EX     = 1'b1;
                en_EX2MEM    = 1'b1;
            end
        end
    end

    // Memory-wait FSM next state and wait counter.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            RUN: begin
                if (mem_req_MEM && !mem_ack) begin
                    state_nxt    = MEMWAIT;
                    wait_cnt_nxt = 8'd1;
                end else begin
                    wait_cnt_nxt = 8'd0;
                end
            end
            MEMWAIT: begin
                if (mem_ack || !mem_req_MEM) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == TMO) begin
                    state_nxt    = FAULT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Saturating count of every cycle the front end is held back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else if ((freeze || lu_stall) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign mem_timeout  = (state == FAULT);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for the combinational controls, hand sequences for memory wait/timeout/reset.
// Latency: controls sampled 1 time unit after inputs change; counters sampled 1 unit after the rising edge.
// Backpressure: memory wait, timeout and reset corner cases are driven as fixed-length sequences.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_ID, rt_ID, rs_EX, rt_EX;
    logic        MemtoReg_EX, RegWrite_EX;
    logic [4:0]  writeAddr_EX;
    logic        RegWrite_MEM;
    logic [4:0]  writeAddr_MEM;
    logic        RegWrite_WB;
    logic [4:0]  writeAddr_WB;
    logic        branch_taken_EX;
    logic        mem_req_MEM, mem_ack;
    logic        pc_en, en_IF2ID, en_ID2EX, en_EX2MEM;
    logic        flush_IF2ID, bubble_ID2EX;
    logic [1:0]  fwdA_EX, fwdB_EX;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [15:0] exp_stall;

    hazard_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .rs_EX(rs_EX), .rt_EX(rt_EX),
        .MemtoReg_EX(MemtoReg_EX), .RegWrite_EX(RegWrite_EX), .writeAddr_EX(writeAddr_EX),
        .RegWrite_MEM(RegWrite_MEM), .writeAddr_MEM(writeAddr_MEM),
        .RegWrite_WB(RegWrite_WB), .writeAddr_WB(writeAddr_WB),
        .branch_taken_EX(branch_taken_EX),
        .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack),
        .pc_en(pc_en), .en_IF2ID(en_IF2ID), .en_ID2EX(en_ID2EX), .en_EX2MEM(en_EX2MEM),
        .flush_IF2ID(flush_IF2ID), .bubble_ID2EX(bubble_ID2EX),
        .fwdA_EX(fwdA_EX), .fwdB_EX(fwdB_EX),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs_id, rt_id, rs_ex, rt_ex;
        logic       mtr, rw_ex;
        logic [4:0] wa_ex;
        logic       rw_mem;
        logic [4:0] wa_mem;
        logic       rw_wb;
        logic [4:0] wa_wb;
        logic       br;
        logic [3:0] x_en;   // {pc, IF2ID, ID2EX, EX2MEM}
        logic       x_fl, x_bu;
        logic [1:0] x_fa, x_fb;
        logic       x_st;   // this cycle counts as a stall
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] en_vec();
        return {pc_en, en_IF2ID, en_ID2EX, en_EX2MEM};
    endfunction

    task automatic clear_inputs();
        rs_ID = 5'd0; rt_ID = 5'd0; rs_EX = 5'd0; rt_EX = 5'd0;
        MemtoReg_EX = 1'b0; RegWrite_EX = 1'b0; writeAddr_EX = 5'd0;
        RegWrite_MEM = 1'b0; writeAddr_MEM = 5'd0;
        RegWrite_WB = 1'b0; writeAddr_WB = 5'd0;
        branch_taken_EX = 1'b0; mem_req_MEM = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        rs_ID = v.rs_id; rt_ID = v.rt_id; rs_EX = v.rs_ex; rt_EX = v.rt_ex;
        MemtoReg_EX = v.mtr; RegWrite_EX = v.rw_ex; writeAddr_EX = v.wa_ex;
        RegWrite_MEM = v.rw_mem; writeAddr_MEM = v.wa_mem;
        RegWrite_WB = v.rw_wb; writeAddr_WB = v.wa_wb;
        branch_taken_EX = v.br; mem_req_MEM = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"},     {12'd0, en_vec()}, 16'h0);
        chk({tag, "_flbu"},   {14'd0, flush_IF2ID, bubble_ID2EX}, 16'h0);
        chk({tag, "_fwd"},    {12'd0, fwdA_EX, fwdB_EX}, 16'h0);
        chk({tag, "_tmo"},    {15'd0, mem_timeout}, 16'h0);
        chk({tag, "_stall"},  stall_cycles, 16'h0);
    endtask

    initial begin
        //               rs_id  rt_id  rs_ex  rt_ex  mtr   rw_ex wa_ex  rwm   wa_mem rwwb  wa_wb  br    en       fl    bu    fa     fb     st
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[1]  = '{5'd5, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0011, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1};
        vecs[2]  = '{5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[3]  = '{5'd3, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0011, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1};
        vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[5]  = '{5'd5, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[6]  = '{5'd5, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b1111, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b1111, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
        vecs[8]  = '{5'd0, 5'd0, 5'd7, 5'd3, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[10] = '{5'd0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0};
        vecs[11] = '{5'd0, 5'd0, 5'd6, 5'd4, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b1, 5'd6, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0};
        vecs[12] = '{5'd0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd2, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[13] = '{5'd5, 5'd0, 5'd7, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 4'b0011, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1};

        // Reset state, with inputs that would otherwise produce branch flush and forwarding.
        clear_inputs();
        rst_n = 1'b0;
        branch_taken_EX = 1'b1;
        RegWrite_MEM = 1'b1; writeAddr_MEM = 5'd7; rs_EX = 5'd7;
        #2;
        chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_stall = 16'd0;

        // Table-driven combinational controls and stall accounting.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply_vec(vecs[i]);
            #1;
            chk($sformatf("v%0d_en", i),    {12'd0, en_vec()}, {12'd0, vecs[i].x_en});
            chk($sformatf("v%0d_flush", i), {15'd0, flush_IF2ID},  {15'd0, vecs[i].x_fl});
            chk($sformatf("v%0d_bub", i),   {15'd0, bubble_ID2EX}, {15'd0, vecs[i].x_bu});
            chk($sformatf("v%0d_fwdA", i),  {14'd0, fwdA_EX}, {14'd0, vecs[i].x_fa});
            chk($sformatf("v%0d_fwdB", i),  {14'd0, fwdB_EX}, {14'd0, vecs[i].x_fb});
            @(posedge clk);
            #1;
            if (vecs[i].x_st) exp_stall = exp_stall + 16'd1;
            chk($sformatf("v%0d_stall", i), stall_cycles, exp_stall);
        end

        // Memory wait: request held, ack in the 4th cycle; branch/load-use ignored while frozen.
        @(negedge clk);
        clear_inputs();
        mem_req_MEM = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) begin
                branch_taken_EX = 1'b1;
                MemtoReg_EX = 1'b1; RegWrite_EX = 1'b1; writeAddr_EX = 5'd5; rs_ID = 5'd5;
            end
            if (c == 3) begin
                branch_taken_EX = 1'b0;
            end
            #1;
            chk($sformatf("wait_c%0d_en", c), {12'd0, en_vec()}, 16'h0);
            chk($sformatf("wait_c%0d_flbu", c), {14'd0, flush_IF2ID, bubble_ID2EX}, 16'h0);
            @(negedge clk);
        end
        clear_inputs();
        mem_req_MEM = 1'b1;
        mem_ack = 1'b1;
        #1;
        chk("wait_ack_en", {12'd0, en_vec()}, 16'hF);
        exp_stall = exp_stall + 16'd3;
        @(negedge clk);
        clear_inputs();
        #1;
        chk("wait_after_en", {12'd0, en_vec()}, 16'hF);
        chk("wait_stall", stall_cycles, exp_stall);
        chk("wait_tmo", {15'd0, mem_timeout}, 16'h0);

        // Request dropped without ack while waiting: back to RUN with the counter cleared.
        @(negedge clk);
        mem_req_MEM = 1'b1;
        @(negedge clk);
        mem_req_MEM = 1'b0;
        #1;
        chk("drop_en", {12'd0, en_vec()}, 16'hF);
        exp_stall = exp_stall + 16'd1;
        @(posedge clk);
        #1;
        chk("drop_stall", stall_cycles, exp_stall);

        // Timeout: 16 unacked cycles reach FAULT, not 15.
        @(negedge clk);
        mem_req_MEM = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("tmo_before", {15'd0, mem_timeout}, 16'h0);
        chk("tmo_before_stall", stall_cycles, exp_stall + 16'd15);
        @(posedge clk);
        #1;
        chk("tmo_set", {15'd0, mem_timeout}, 16'h1);
        @(negedge clk);
        mem_req_MEM = 1'b0;
        #1;
        chk("fault_en", {12'd0, en_vec()}, 16'h0);
        chk("fault_tmo_sticky", {15'd0, mem_timeout}, 16'h1);

        // FAULT holds freeze forever: stall counter must saturate, never wrap.
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_ffff", stall_cycles, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold", stall_cycles, 16'hFFFF);
        chk("sat_en", {12'd0, en_vec()}, 16'h0);

        // Reset pulse out of FAULT, then operation resumes.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_fault");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_fault_en", {12'd0, en_vec()}, 16'hF);

        // Reset asserted off-edge in the middle of a memory wait.
        @(negedge clk);
        mem_req_MEM = 1'b1;
        RegWrite_MEM = 1'b1; writeAddr_MEM = 5'd7; rs_EX = 5'd7;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        mem_req_MEM = 1'b0;
        branch_taken_EX = 1'b1;
        #1;
        chk_reset_vals("rst_wait");
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        #1;
        chk("rel_en", {12'd0, en_vec()}, 16'hF);
        @(posedge clk);
        #1;
        chk("rel_stall", stall_cycles, 16'h0);
        chk("rel_tmo", {15'd0, mem_timeout}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Parameters
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of consecutive memory-wait cycles before fault (range 1..255).

Interface
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports rs_ID and rt_ID, inputs, 5 bits each: source register addresses of the instruction in ID.
REQ-005 SHALL have ports rs_EX and rt_EX, inputs, 5 bits each: source register addresses of the instruction in EX.
REQ-006 SHALL have ports MemtoReg_EX, RegWrite_EX (input, 1 bit each) and writeAddr_EX (input, 5 bits): EX-stage load/writeback controls.
REQ-007 SHALL have ports RegWrite_MEM (input, 1 bit) and writeAddr_MEM (input, 5 bits), plus RegWrite_WB (input, 1 bit) and writeAddr_WB (input, 5 bits).
REQ-008 SHALL have port branch_taken_EX, input, 1 bit: a resolved taken branch or jump is in EX.
REQ-009 SHALL have ports mem_req_MEM and mem_ack, inputs, 1 bit each: data-memory access pending in MEM, and its completion.
REQ-010 SHALL have ports pc_en, en_IF2ID, en_ID2EX and en_EX2MEM, outputs, 1 bit each: load enables for the PC and the pipeline registers.
REQ-011 SHALL have ports flush_IF2ID and bubble_ID2EX, outputs, 1 bit each: clear IF/ID; load zeroed controls into ID/EX.
REQ-012 SHALL have ports fwdA_EX and fwdB_EX, outputs, 2 bits each: operand source, where 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
REQ-013 SHALL have ports mem_timeout (output, 1 bit, sticky fault) and stall_cycles (output, 16 bits, stall counter).

Function
REQ-014 SHALL implement FSM states RUN, MEMWAIT and FAULT, with state, wait counter and stall_cycles registered and all other outputs combinational.
REQ-015 SHALL define freeze = (state != FAULT) & mem_req_MEM & !mem_ack, or state == FAULT.
REQ-016 While freeze is high, SHALL drive pc_en, en_IF2ID, en_ID2EX and en_EX2MEM to 0 and flush_IF2ID and bubble_ID2EX to 0; branch and load-use are ignored.
REQ-017 SHALL define loaduse = MemtoReg_EX & RegWrite_EX & (writeAddr_EX != 0) & (writeAddr_EX == rs_ID | writeAddr_EX == rt_ID).
REQ-018 When not frozen and branch_taken_EX = 1, SHALL assert flush_IF2ID = 1 and bubble_ID2EX = 1 with all enables at 1; the branch takes priority over loaduse.
REQ-019 When not frozen, branch_taken_EX = 0 and loaduse = 1, SHALL drive pc_en = 0, en_IF2ID = 0, bubble_ID2EX = 1 and en_ID2EX = 1, giving exactly one bubble per load.
REQ-020 Otherwise SHALL drive all enables to 1 and flush_IF2ID and bubble_ID2EX to 0.
REQ-021 For fwdA_EX, SHALL select 10 if RegWrite_MEM & writeAddr_MEM != 0 & writeAddr_MEM == rs_EX; else 01 if the same condition holds for WB; else 00. fwdB_EX SHALL do the same using rt_EX. MEM has priority over WB; register 0 is never forwarded.
REQ-022 RUN -> MEMWAIT SHALL occur when mem_req_MEM & !mem_ack, loading the wait counter with 1.
REQ-023 In MEMWAIT with mem_ack = 1, SHALL release freeze in the same cycle and return to RUN on the next edge with the counter cleared.
REQ-024 In MEMWAIT with no ack, SHALL increment the counter; when the counter equals MEM_TIMEOUT with no ack, SHALL go to FAULT.
REQ-025 If mem_req_MEM drops without an ack while in MEMWAIT, SHALL return to RUN.
REQ-026 FAULT SHALL be terminal until reset, with mem_timeout = 1.
REQ-027 SHALL increment stall_cycles by 1 on every edge where freeze or the loaduse stall is active, saturating at 0xFFFF without wrap.

Reset
REQ-028 While rst_n = 0, SHALL force state = RUN, wait counter = 0, stall_cycles = 0, mem_timeout = 0, all enables = 0, flush_IF2ID = bubble_ID2EX = 0 and fwdA_EX = fwdB_EX = 00, regardless of clk.
REQ-029 An assertion of rst_n mid-MEMWAIT or in FAULT SHALL abort immediately to the reset values; after release, operation SHALL begin in RUN on the first edge.

Verification
REQ-030 The bench SHALL cover load-use: MemtoReg_EX = 1, RegWrite_EX = 1, writeAddr_EX = 5, rs_ID = 5 -> pc_en = 0, en_IF2ID = 0, bubble_ID2EX = 1 for one cycle, and stall_cycles increments by 1.
REQ-031 The bench SHALL cover branch plus load-use in the same cycle: branch_taken_EX = 1 together with the loaduse condition -> flush_IF2ID = 1, bubble_ID2EX = 1, pc_en = 1.
REQ-032 The bench SHALL cover forwarding priority: writeAddr_MEM = writeAddr_WB = rs_EX = 7, both RegWrite = 1 -> fwdA_EX = 10; with rs_EX = 0 -> fwdA_EX = 00.
REQ-033 The bench SHALL cover a memory wait: mem_req_MEM = 1 held with ack on the 4th cycle -> enables at 0 for 3 cycles, at 1 in the ack cycle, state RUN after it, stall_cycles = 3.
REQ-034 The bench SHALL cover timeout: mem_req_MEM = 1 and no ack for MEM_TIMEOUT + 1 cycles -> mem_timeout = 1, enables stay at 0 until rst_n pulses low.
REQ-035 The bench SHALL cover reset and saturation: stall_cycles preloaded to 0xFFFF by holding freeze -> remains 0xFFFF; then rst_n low mid-MEMWAIT -> all outputs at reset values immediately, without waiting for a clock edge.
